// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: state encoding, default widths and reset PC.
package fetch_pkg;

    localparam int unsigned DefaultIw = 16;
    localparam int unsigned DefaultOw = 8;
    localparam int unsigned DefaultCw = 16;
    localparam int unsigned ResetPc   = 0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Control/decode <-> fetch-stage signal bundle; master drives requests, slave is the fetch stage.
interface inst_fetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned IW = DefaultIw,
    parameter int unsigned OW = DefaultOw,
    parameter int unsigned CW = DefaultCw
);
    logic          Start;
    logic          Stall;
    logic          Halt;
    logic          BranchEn;
    logic          Taken;
    logic [OW-1:0] Offset;
    logic          JumpEn;
    logic [IW-1:0] Target;
    logic [IW-1:0] InstAddress;
    logic          Running;
    logic          Done;
    logic [CW-1:0] CycleCount;

    modport master (
        output Start, Stall, Halt, BranchEn, Taken, Offset, JumpEn, Target,
        input  InstAddress, Running, Done, CycleCount
    );

    modport slave (
        input  Start, Stall, Halt, BranchEn, Taken, Offset, JumpEn, Target,
        output InstAddress, Running, Done, CycleCount
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// PC and fetch sequencing: IDLE/RUN/HALTED control with jump, relative branch, increment and stall.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned IW = DefaultIw,
    parameter int unsigned OW = DefaultOw,
    parameter int unsigned CW = DefaultCw
) (
    input  logic     CLK,
    input  logic     Reset_n,
    inst_fetch_if.slave bus
);

    fetch_state_e  state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [IW-1:0] offset_ext;
    logic          cnt_clear;
    logic          cnt_en;

    assign offset_ext = {{(IW-OW){bus.Offset[OW-1]}}, bus.Offset};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            StIdle, StHalted: begin
                if (bus.Start) begin
                    state_d   = StRun;
                    pc_d      = IW'(ResetPc);
                    cnt_clear = 1'b1;
                end
            end
            StRun: begin
                // Stalled cycles still count as time spent running.
                cnt_en = 1'b1;
                if (!bus.Stall) begin
                    if (bus.Halt) begin
                        state_d = StHalted;
                    end else if (bus.JumpEn) begin
                        pc_d = bus.Target;
                    end else if (bus.BranchEn && bus.Taken) begin
                        pc_d = pc_q + offset_ext;
                    end else begin
                        pc_d = pc_q + IW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            pc_q    <= IW'(ResetPc);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sat_counter #(
        .W (CW)
    ) u_cycle_counter (
        .clk    (CLK),
        .rst_n  (Reset_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (bus.CycleCount)
    );

    assign bus.InstAddress = pc_q;
    assign bus.Running     = (state_q == StRun);
    assign bus.Done        = (state_q == StHalted);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic against a behavioural model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stall = 1'b0, halt = 1'b0;
    logic        branch_en = 1'b0, taken = 1'b0, jump_en = 1'b0;
    logic [7:0]  offset = '0;
    logic [15:0] target = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: running/done flags, PC and cycle count as plain integers.
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    int m_pc   = 0;
    int m_cnt  = 0;

    logic [34:0] obs, exp;

    inst_fetch_if #(.IW(16), .OW(8), .CW(16)) bus ();
    inst_fetch_if #(.IW(16), .OW(8), .CW(4))  bus4 ();

    assign bus.Start = start;      assign bus4.Start = start;
    assign bus.Stall = stall;      assign bus4.Stall = stall;
    assign bus.Halt = halt;        assign bus4.Halt = halt;
    assign bus.BranchEn = branch_en; assign bus4.BranchEn = branch_en;
    assign bus.Taken = taken;      assign bus4.Taken = taken;
    assign bus.Offset = offset;    assign bus4.Offset = offset;
    assign bus.JumpEn = jump_en;   assign bus4.JumpEn = jump_en;
    assign bus.Target = target;    assign bus4.Target = target;

    inst_fetch #(.IW(16), .OW(8), .CW(16)) dut (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    inst_fetch #(.IW(16), .OW(8), .CW(4)) dut4 (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus4.slave)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs sampled at that edge.
    task automatic step();
        int off;
        if (rst_n) begin
            if (!m_run) begin
                if (start) begin
                    m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
                end
            end else begin
                if (m_cnt < 65535) m_cnt++;
                if (!stall) begin
                    off = (offset >= 8'd128) ? int'(offset) - 256 : int'(offset);
                    if (halt) begin
                        m_run = 0; m_done = 1;
                    end else if (jump_en) begin
                        m_pc = int'(target);
                    end else if (branch_en && taken) begin
                        m_pc = (m_pc + off) & 32'hFFFF;
                    end else begin
                        m_pc = (m_pc + 1) & 32'hFFFF;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; halt = 0; branch_en = 0; taken = 0; jump_en = 0;
        offset = '0; target = '0;
    endtask

    task automatic goto_pc(input logic [15:0] pc);
        clear_inputs();
        jump_en = 1; target = pc;
        step();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #2;
        obs = {bus.InstAddress, bus.Running, bus.Done, bus.CycleCount, 1'b0};
        n_checks++;
        if (obs !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%0d run=%b done=%b cnt=%0d, want all 0",
                     bus.InstAddress, bus.Running, bus.Done, bus.CycleCount);
        end
        #10 rst_n = 1;
        model_reset();
        step(); step();
        n_checks++;
        if (bus.Running !== 1'b0 || bus.InstAddress !== 16'd0) begin
            n_fail++;
            $display("FAIL idle_without_start: got run=%b addr=%0d, want run=0 addr=0",
                     bus.Running, bus.InstAddress);
        end
    endtask

    task automatic test_sequential();
        clear_inputs();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.InstAddress !== 16'(i) || bus.Running !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_addr_%0d: got addr=%0d run=%b, want addr=%0d run=1",
                         i, bus.InstAddress, bus.Running, i);
            end
            step();
        end
        n_checks++;
        if (bus.CycleCount !== 16'd4) begin
            n_fail++;
            $display("FAIL seq_count: got %0d, want 4", bus.CycleCount);
        end
    endtask

    task automatic test_branch();
        goto_pc(16'd10);
        branch_en = 1; taken = 1; offset = 8'hFD;
        step();
        n_checks++;
        if (bus.InstAddress !== 16'd7) begin
            n_fail++;
            $display("FAIL branch_back: got %0d, want 7", bus.InstAddress);
        end
        goto_pc(16'd10);
        branch_en = 1; taken = 0; offset = 8'hFD;
        step();
        n_checks++;
        if (bus.InstAddress !== 16'd11) begin
            n_fail++;
            $display("FAIL branch_not_taken: got %0d, want 11", bus.InstAddress);
        end
        goto_pc(16'd0);
        branch_en = 1; taken = 1; offset = 8'hFF;
        step();
        n_checks++;
        if (bus.InstAddress !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL branch_wrap: got %h, want ffff", bus.InstAddress);
        end
        goto_pc(16'd30);
        taken = 1; offset = 8'h05;
        step();
        n_checks++;
        if (bus.InstAddress !== 16'd31) begin
            n_fail++;
            $display("FAIL taken_without_branch: got %0d, want 31", bus.InstAddress);
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        goto_pc(16'd5);
        jump_en = 1; target = 16'd100; branch_en = 1; taken = 1; offset = 8'd3;
        step();
        n_checks++;
        if (bus.InstAddress !== 16'd100) begin
            n_fail++;
            $display("FAIL jump_over_branch: got %0d, want 100", bus.InstAddress);
        end
        goto_pc(16'd5);
        jump_en = 1; target = 16'd100; branch_en = 1; taken = 1; offset = 8'd3; halt = 1;
        step();
        clear_inputs();
        n_checks++;
        if (bus.InstAddress !== 16'd5 || bus.Done !== 1'b1 || bus.Running !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_priority: got addr=%0d done=%b run=%b, want 5/1/0",
                     bus.InstAddress, bus.Done, bus.Running);
        end
    endtask

    task automatic test_restart();
        int cnt_halt;
        cnt_halt = m_cnt;
        step(); step(); step();
        n_checks++;
        if (bus.CycleCount !== 16'(cnt_halt) || bus.InstAddress !== 16'd5) begin
            n_fail++;
            $display("FAIL halted_hold: got cnt=%0d addr=%0d, want cnt=%0d addr=5",
                     bus.CycleCount, bus.InstAddress, cnt_halt);
        end
        start = 1;
        step();
        start = 0;
        n_checks++;
        if (bus.InstAddress !== 16'd0 || bus.Done !== 1'b0 || bus.CycleCount !== 16'd0
            || bus.Running !== 1'b1) begin
            n_fail++;
            $display("FAIL restart: got addr=%0d done=%b cnt=%0d run=%b, want 0/0/0/1",
                     bus.InstAddress, bus.Done, bus.CycleCount, bus.Running);
        end
    endtask

    task automatic test_stall();
        int cnt0;
        goto_pc(16'd20);
        cnt0 = m_cnt;
        stall = 1; jump_en = 1; target = 16'h1234; halt = 1;
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (bus.InstAddress !== 16'd20 || bus.CycleCount !== 16'(cnt0 + 3)
            || bus.Running !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: got addr=%0d cnt=%0d run=%b, want 20/%0d/1",
                     bus.InstAddress, bus.CycleCount, bus.Running, cnt0 + 3);
        end
        stall = 0; halt = 0;
        step();
        clear_inputs();
        n_checks++;
        if (bus.InstAddress !== 16'h1234) begin
            n_fail++;
            $display("FAIL stall_release: got %h, want 1234", bus.InstAddress);
        end
    endtask

    task automatic test_saturation();
        halt = 1;
        step();
        clear_inputs();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 20; i++) step();
        n_checks++;
        if (bus4.CycleCount !== 4'd15 || bus.CycleCount !== 16'd20) begin
            n_fail++;
            $display("FAIL saturation: got cnt4=%0d cnt16=%0d, want 15/20",
                     bus4.CycleCount, bus.CycleCount);
        end
    endtask

    task automatic test_async_reset();
        stall = 1;
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        n_checks++;
        if (bus.InstAddress !== 16'd0 || bus.Running !== 1'b0 || bus.CycleCount !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%0d run=%b cnt=%0d, want 0/0/0",
                     bus.InstAddress, bus.Running, bus.CycleCount);
        end
        model_reset();
        #2;
        rst_n = 1;
        clear_inputs();
        step(); step(); step();
        n_checks++;
        if (bus.Running !== 1'b0 || bus.Done !== 1'b0 || bus.InstAddress !== 16'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got run=%b done=%b addr=%0d, want 0/0/0",
                     bus.Running, bus.Done, bus.InstAddress);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 9) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            halt      = ($urandom_range(0, 24) == 0);
            jump_en   = ($urandom_range(0, 5) == 0);
            branch_en = ($urandom_range(0, 2) == 0);
            taken     = $urandom_range(0, 1) != 0;
            offset    = 8'($urandom);
            target    = 16'($urandom);
            step();
            exp = {16'(m_pc), m_run, m_done, 16'(m_cnt), 1'b0};
            obs = {bus.InstAddress, bus.Running, bus.Done, bus.CycleCount, 1'b0};
            n_checks++;
            if (obs !== exp || bus4.CycleCount !== 4'((m_cnt > 15) ? 15 : m_cnt)) begin
                n_fail++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_%0d: got addr=%0d run=%b done=%b cnt=%0d cnt4=%0d, want addr=%0d run=%b done=%b cnt=%0d",
                             i, bus.InstAddress, bus.Running, bus.Done, bus.CycleCount,
                             bus4.CycleCount, m_pc, m_run, m_done, m_cnt);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_priority();
        test_restart();
        test_stall();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
